// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch hazard/forwarding controller.
// Holds the forward-select encodings, the EX/MEM/WB tag entry and the tag-match helper.
package branch_hazard_ctrl_pkg;

    localparam int TAG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rd;
        logic             we;
        logic             ld;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{valid: 1'b0, rd: {TAG_W{1'b0}}, we: 1'b0, ld: 1'b0};

    // x0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic tag_hit(
        input logic             valid,
        input logic             we,
        input logic [TAG_W-1:0] rd,
        input logic [TAG_W-1:0] src
    );
        return valid & we & (rd == src) & (src != {TAG_W{1'b0}});
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_opchk.sv
// Per-operand hazard check for the branch comparator: decides stall and forward
// select for one source index against the EX/MEM/WB tags, youngest entry first.
module branch_hazard_ctrl_opchk
    import branch_hazard_ctrl_pkg::*;
(
    input  logic             en,
    input  logic [TAG_W-1:0] src,
    input  tag_t             ex_tag,
    input  tag_t             mem_tag,
    input  tag_t             wb_tag,
    output logic             stall,
    output logic [1:0]       sel
);

    logic ex_hit_s;
    logic mem_hit_s;
    logic wb_hit_s;
    logic unused_ld_s;

    assign ex_hit_s    = tag_hit(ex_tag.valid,  ex_tag.we,  ex_tag.rd,  src);
    assign mem_hit_s   = tag_hit(mem_tag.valid, mem_tag.we, mem_tag.rd, src);
    assign wb_hit_s    = tag_hit(wb_tag.valid,  wb_tag.we,  wb_tag.rd,  src);
    assign unused_ld_s = ex_tag.ld ^ wb_tag.ld;

    // Priority resolution: EX producer or MEM load cannot feed the ID comparator yet.
    always_comb begin
        stall = 1'b0;
        sel   = FWD_RF;
        if (!en) begin
            stall = 1'b0;
            sel   = FWD_RF;
        end else if (ex_hit_s) begin
            stall = 1'b1;
            sel   = FWD_RF;
        end else if (mem_hit_s && mem_tag.ld) begin
            stall = 1'b1;
            sel   = FWD_RF;
        end else if (mem_hit_s) begin
            stall = 1'b0;
            sel   = FWD_EXMEM;
        end else if (wb_hit_s) begin
            stall = 1'b0;
            sel   = FWD_MEMWB;
        end else begin
            stall = 1'b0;
            sel   = FWD_RF;
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch/JALR operand hazard and forwarding controller for the ID-stage comparator.
// Optional stall performance counter is built when BRANCH_HAZ_PERF_EN is defined.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int XLEN_TAG = TAG_W,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ext_hold,
    input  logic                id_valid,
    input  logic                id_is_branch,
    input  logic                id_uses_rs2,
    input  logic [XLEN_TAG-1:0] id_rs1,
    input  logic [XLEN_TAG-1:0] id_rs2,
    input  logic [XLEN_TAG-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_flush,
    output logic [1:0]          forwardA,
    output logic [1:0]          forwardB,
    output logic                stall,
    output logic [CNT_W-1:0]    stall_cnt
);

    tag_t ex_r;
    tag_t mem_r;
    tag_t wb_r;
    tag_t id_tag_s;

    logic       chk_a_en_s;
    logic       chk_b_en_s;
    logic       stall_a_s;
    logic       stall_b_s;
    logic [1:0] sel_a_s;
    logic [1:0] sel_b_s;
    logic       stall_s;

    // A held pipeline or a non-branch in ID leaves the comparator path idle.
    assign chk_a_en_s = id_valid & id_is_branch & ~ext_hold;
    assign chk_b_en_s = chk_a_en_s & id_uses_rs2;

    branch_hazard_ctrl_opchk u_chk_rs1 (
        .en      (chk_a_en_s),
        .src     (id_rs1),
        .ex_tag  (ex_r),
        .mem_tag (mem_r),
        .wb_tag  (wb_r),
        .stall   (stall_a_s),
        .sel     (sel_a_s)
    );

    branch_hazard_ctrl_opchk u_chk_rs2 (
        .en      (chk_b_en_s),
        .src     (id_rs2),
        .ex_tag  (ex_r),
        .mem_tag (mem_r),
        .wb_tag  (wb_r),
        .stall   (stall_b_s),
        .sel     (sel_b_s)
    );

    assign stall_s  = stall_a_s | stall_b_s;
    assign stall    = stall_s;
    assign forwardA = sel_a_s;
    assign forwardB = sel_b_s;

    // Tag presented to EX: a stalled or flushed ID instruction becomes a bubble.
    always_comb begin
        id_tag_s = TAG_BUBBLE;
        if (id_valid && !stall_s && !id_flush) begin
            id_tag_s.valid = 1'b1;
            id_tag_s.rd    = id_rd;
            id_tag_s.we    = id_reg_write;
            id_tag_s.ld    = id_mem_read;
        end else begin
            id_tag_s = TAG_BUBBLE;
        end
    end

    // Tag pipeline advance; reset outranks the global hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_r  <= TAG_BUBBLE;
            mem_r <= TAG_BUBBLE;
            wb_r  <= TAG_BUBBLE;
        end else if (ext_hold) begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= id_tag_s;
        end
    end

`ifdef BRANCH_HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of stalled, non-held cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!ext_hold && stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: an instruction-age reference model predicts
// stall/forward selects/counter each cycle; a negedge monitor pops and compares.
module tb_branch_hazard_ctrl;

    localparam int CNT_W = 16;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    typedef struct {
        logic       stall;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST, ext_hold, id_valid, id_is_branch, id_uses_rs2;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_reg_write, id_mem_read, id_flush;
    logic [1:0]       forwardA, forwardB;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int     total = 0;
    int     bad = 0;
    exp_t   sb_q[$];
    instr_t hist[$];   // issued instructions, index 0 = issued most recently
    int     m_cnt;

    always #5 CLK = ~CLK;

    branch_hazard_ctrl #(.XLEN_TAG(5), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ext_hold(ext_hold), .id_valid(id_valid),
        .id_is_branch(id_is_branch), .id_uses_rs2(id_uses_rs2), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_flush(id_flush), .forwardA(forwardA),
        .forwardB(forwardB), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Find the youngest writer of s; its age decides whether the value is reachable.
    function automatic void op_eval(input logic [4:0] s, output logic st, output logic [1:0] sel);
        st  = 1'b0;
        sel = 2'b00;
        if (s != 5'd0) begin
            for (int d = 0; d < 3; d++) begin
                if (hist[d].valid && hist[d].we && hist[d].rd == s) begin
                    if (d == 0) st = 1'b1;                  // result not computed yet
                    else if (d == 1 && hist[d].ld) st = 1'b1; // load data still in memory
                    else if (d == 1) sel = 2'b10;
                    else sel = 2'b01;
                    break;
                end
            end
        end
    endfunction

    task automatic cycle(input logic rst, input logic hold, input logic v, input logic br,
                         input logic u2, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic we, input logic ld, input logic fl);
        exp_t       e;
        logic       sa, sb;
        logic [1:0] fa, fb;
        instr_t     n;
        RST = rst; ext_hold = hold; id_valid = v; id_is_branch = br; id_uses_rs2 = u2;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_reg_write = we; id_mem_read = ld; id_flush = fl;
        sa = 1'b0; sb = 1'b0; fa = 2'b00; fb = 2'b00;
        if (v && br && !hold) begin
            op_eval(r1, sa, fa);
            if (u2) op_eval(r2, sb, fb);
        end
        e.stall = sa | sb; e.fa = fa; e.fb = fb;
`ifdef BRANCH_HAZ_PERF_EN
        e.cnt = m_cnt;
`else
        e.cnt = 0;
`endif
        sb_q.push_back(e);
        @(posedge CLK);
        if (rst) begin
            hist = {};
            for (int i = 0; i < 3; i++) hist.push_back('{1'b0, 5'd0, 1'b0, 1'b0});
            m_cnt = 0;
        end else if (!hold) begin
            n.valid = v & ~e.stall & ~fl; n.rd = rd; n.we = we; n.ld = ld;
            hist.push_front(n);
            void'(hist.pop_back());
            if (e.stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every presented cycle is compared against the oldest prediction.
    always @(negedge CLK) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stall", int'(stall), int'(e.stall));
            chk("forwardA", int'(forwardA), int'(e.fa));
            chk("forwardB", int'(forwardB), int'(e.fb));
            chk("stall_cnt", int'(stall_cnt), e.cnt);
        end
    end

    // Shorthands: non-branch writer and branch in ID.
    task automatic wr(input logic [4:0] rd, input logic ld);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, rd, 1'b1, ld, 1'b0);
    endtask
    task automatic br(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                      input logic rst, input logic hold);
        cycle(rst, hold, 1'b1, 1'b1, u2, r1, r2, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic nop();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; ext_hold = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_uses_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_flush = 1'b0; m_cnt = 0;
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) hist.push_back('{1'b0, 5'd0, 1'b0, 1'b0});
        nop();                                         // reset state
        br(5'd5, 5'd6, 1'b1, 1'b0, 1'b0);              // branch right after reset: no hazard
        wr(5'd5, 1'b0); br(5'd5, 5'd6, 1'b1, 1'b0, 1'b0); br(5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();
        wr(5'd7, 1'b1); repeat (3) br(5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        nop(); nop(); nop();
        wr(5'd0, 1'b0); br(5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        wr(5'd3, 1'b0); wr(5'd3, 1'b0); nop(); br(5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        wr(5'd9, 1'b0); br(5'd1, 5'd9, 1'b0, 1'b0, 1'b0);
        nop(); nop(); nop();
        wr(5'd7, 1'b1); br(5'd1, 5'd7, 1'b1, 1'b1, 1'b0); br(5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        wr(5'd7, 1'b1); repeat (3) br(5'd1, 5'd7, 1'b1, 1'b0, 1'b1);
        repeat (2) br(5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0));
        end
        @(negedge CLK);
        @(negedge CLK);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
